instruction_fetch_haz: RTL

// - Fetch stage directly upstream of instruction_memory_haz: owns the PC, drives the memory word address, and

---
 rtl/instruction_fetch_haz_if.sv | 27 ++
 rtl/instruction_fetch_haz.sv | 90 +++++++++
 2 files changed

// File: rtl/instruction_fetch_haz_if.sv
// Fetch-stage bundle: hazard controls, execute redirect, instruction-memory port and IF/ID register outputs.
// master = fetch stage, slave = surrounding pipeline/memory.
interface instruction_fetch_haz_if #(
    parameter int CNT_W = 16
);
    logic             stall;
    logic             flush;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic [31:0]      imem_dataout;
    logic [31:0]      imem_address;
    logic [31:0]      ifid_instr;
    logic [31:0]      ifid_pc;
    logic             ifid_valid;
    logic             ifid_jump_taken;
    logic [CNT_W-1:0] fetch_count;

    modport master (
        input  stall, flush, redirect_valid, redirect_pc, imem_dataout,
        output imem_address, ifid_instr, ifid_pc, ifid_valid, ifid_jump_taken, fetch_count
    );

    modport slave (
        output stall, flush, redirect_valid, redirect_pc, imem_dataout,
        input  imem_address, ifid_instr, ifid_pc, ifid_valid, ifid_jump_taken, fetch_count
    );
endinterface

// File: rtl/instruction_fetch_haz.sv
// Fetch stage: PC register, IF/ID pipeline register, stall/flush/redirect handling, saturating fetch counter.
// Optional macro IFETCH_JUMP_SHORTCUT_EN: follow JUMP words directly at fetch time.
module instruction_fetch_haz #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] NOP_WORD = 32'h0,
    parameter int          CNT_W    = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    instruction_fetch_haz_if.master bus
);
    typedef enum logic {RUN, HOLD} state_t;

    state_t           state;
    logic [31:0]      pc;
    logic [31:0]      ifid_instr;
    logic [31:0]      ifid_pc;
    logic             ifid_valid;
    logic             ifid_jump_taken;
    logic [CNT_W-1:0] fetch_count;

    logic [31:0]      seq_pc;
    logic             capture_jump;
    logic [31:0]      capture_next_pc;

    assign seq_pc = pc + 32'd1;

`ifdef IFETCH_JUMP_SHORTCUT_EN
    localparam logic [5:0] JUMP_OP = 6'b010101;
    assign capture_jump = (bus.imem_dataout[31:26] == JUMP_OP);
`else
    // Without predecode a captured JUMP is an ordinary word, so the taken flag never rises.
    assign capture_jump = 1'b0;
`endif

    assign capture_next_pc = capture_jump ? {6'b0, bus.imem_dataout[25:0]} : seq_pc;

    assign bus.imem_address    = pc;
    assign bus.ifid_instr      = ifid_instr;
    assign bus.ifid_pc         = ifid_pc;
    assign bus.ifid_valid      = ifid_valid;
    assign bus.ifid_jump_taken = ifid_jump_taken;
    assign bus.fetch_count     = fetch_count;

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= RUN;
            pc              <= RESET_PC;
            ifid_instr      <= NOP_WORD;
            ifid_pc         <= 32'h0;
            ifid_valid      <= 1'b0;
            ifid_jump_taken <= 1'b0;
            fetch_count     <= '0;
        end else begin
            case (state)
                RUN:  if (bus.stall && !bus.redirect_valid) state <= HOLD;
                HOLD: if (!bus.stall || bus.redirect_valid) state <= RUN;
                default: state <= RUN;
            endcase

            if (bus.redirect_valid) begin
                pc              <= bus.redirect_pc;
                ifid_instr      <= NOP_WORD;
                ifid_valid      <= 1'b0;
                ifid_jump_taken <= 1'b0;
            end else if (bus.stall) begin
                // A stall alone freezes everything; a stall with flush still squashes IF/ID.
                if (bus.flush) begin
                    ifid_instr      <= NOP_WORD;
                    ifid_valid      <= 1'b0;
                    ifid_jump_taken <= 1'b0;
                end
            end else if (bus.flush) begin
                pc              <= seq_pc;
                ifid_instr      <= NOP_WORD;
                ifid_valid      <= 1'b0;
                ifid_jump_taken <= 1'b0;
            end else begin
                pc              <= capture_next_pc;
                ifid_instr      <= bus.imem_dataout;
                ifid_pc         <= pc;
                ifid_valid      <= 1'b1;
                ifid_jump_taken <= capture_jump;
                if (fetch_count != {CNT_W{1'b1}})
                    fetch_count <= fetch_count + 1'b1;
            end
        end
    end
endmodule
